// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, routing tags and CPU port states for the video RAM arbiter
package vram_pkg;
  localparam int VADDR_W = 13;
  localparam int VDATA_W = 16;
  localparam int QUARTER_TH = 192;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_t;
  typedef enum logic [1:0] {CPU_IDLE, CPU_ISSUE, CPU_WAIT, CPU_DONE} cpu_st_t;
endpackage

// File: rtl/vram_if.sv
// vram_if: CPU request/response and RAM word port signals
interface vram_if;
  import vram_pkg::*;
  logic cpu_req, cpu_we, cpu_ack, ram_en, ram_we;
  logic [1:0] cpu_be, ram_be;
  logic [VADDR_W-1:0] cpu_addr, ram_addr;
  logic [VDATA_W-1:0] cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, ram_rdata,
    input  cpu_ack, cpu_rdata, ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, ram_rdata,
    output cpu_ack, cpu_rdata, ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_cpu_port.sv
// vram_cpu_port: CPU handshake, exactly one RAM access per held request
module vram_cpu_port
  import vram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  output logic issue,
  output logic ack
);
  localparam logic [1:0] LAST = 2'(RD_LAT - 1);
  cpu_st_t st, st_n;
  logic [1:0] cnt;
  // state register and cycles-since-issue counter
  always_ff @(posedge clk)
    if (rst) begin
      st <= CPU_IDLE;
      cnt <= '0;
    end else begin
      st <= st_n;
      cnt <= (st == CPU_WAIT) ? cnt + 2'd1 : '0;
    end
  // next state: a blocked issue retries, DONE waits for req to drop
  always_comb begin
    st_n = st;
    case (st)
      CPU_IDLE:  st_n = req ? CPU_ISSUE : CPU_IDLE;
      CPU_ISSUE: st_n = grant ? CPU_WAIT : CPU_ISSUE;
      CPU_WAIT:  st_n = (cnt == LAST) ? CPU_DONE : CPU_WAIT;
      default:   st_n = req ? CPU_DONE : CPU_IDLE;
    endcase
  end
  // outputs: issue when granted, ack in the cycle the data returns
  always_comb begin
    issue = st == CPU_ISSUE && grant;
    ack = st == CPU_WAIT && cnt == LAST;
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the video RAM word port between display fetch and CPU
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int YMAX = 625,
  parameter int FETCH_PH = 4,
  parameter int LOAD_PH = 15,
  parameter int PREFETCH_X = 692,
  parameter int SCROLL_RST = 216
) (
  input  logic               clk,
  input  logic               res,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [7:0]         scroll_i,
  input  logic               quarter_i,
  vram_if.slave              bus,
  output logic [VDATA_W-1:0] data_o,
  output logic               load_o
);
  logic [7:0] scroll_q, line;
  logic [8:0] tl;
  logic [4:0] col;
  logic quarter_q, slot_cur, slot_pre, slot, supp, disp_rd, load;
  logic issue_c, ack_c, cpu_issue, rd_ack;
  logic [VDATA_W-1:0] pend_q, data_q, rdata_q;
  tag_t tag_q [RD_LAT];
  tag_t tag_in, tag_out;
  vram_cpu_port #(.RD_LAT(RD_LAT)) u_cpu (
    .clk(clk), .rst(res), .req(bus.cpu_req), .grant(!disp_rd), .issue(issue_c), .ack(ack_c)
  );
  // display slot decode; tl is the target y halved (line before scroll)
  always_comb begin
    slot_cur = x[3:0] == 4'(FETCH_PH) && !x[9] && x[8:4] != 5'd31;
    slot_pre = x == 10'(PREFETCH_X);
    slot = slot_cur || slot_pre;
    tl = slot_pre ? ((y == 10'(YMAX)) ? 9'd0 : 9'((y + 10'd1) >> 1)) : y[9:1];
    col = slot_pre ? 5'd0 : x[8:4] + 5'd1;
    supp = tl[8] || (quarter_q && tl[7:0] < 8'(QUARTER_TH));
    line = tl[7:0] + scroll_q;
    disp_rd = slot && !supp && !res;
    load = x[3:0] == 4'(LOAD_PH) && !res;
    cpu_issue = issue_c && !res;
    tag_in = disp_rd ? TAG_DISP : cpu_issue ? TAG_CPU : TAG_NONE;
    tag_out = tag_q[RD_LAT-1];
    rd_ack = tag_out == TAG_CPU && !bus.cpu_we && !res;
  end
  // RAM port mux (display wins), CPU response and shifter outputs, all 0 in reset
  always_comb begin
    bus.ram_en = disp_rd || cpu_issue;
    bus.ram_we = cpu_issue && bus.cpu_we;
    bus.ram_be = cpu_issue ? bus.cpu_be : '0;
    bus.ram_addr = disp_rd ? {line, col} : cpu_issue ? bus.cpu_addr : '0;
    bus.ram_wdata = (cpu_issue && bus.cpu_we) ? bus.cpu_wdata : '0;
    bus.cpu_ack = ack_c && !res;
    bus.cpu_rdata = res ? '0 : rd_ack ? bus.ram_rdata : rdata_q;
    data_o = res ? '0 : load ? pend_q : data_q;
    load_o = load;
  end
  // frame-latched scroll/quarter, read tag pipe, display buffer and CPU read hold
  always_ff @(posedge clk)
    if (res) begin
      scroll_q <= 8'(SCROLL_RST);
      quarter_q <= 1'b0;
      pend_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      if (x == 10'd0 && y == 10'(YMAX)) begin
        scroll_q <= scroll_i;
        quarter_q <= quarter_i;
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (slot && supp) pend_q <= '0;
      else if (tag_out == TAG_DISP) pend_q <= bus.ram_rdata;
      if (load) data_q <= pend_q;
      if (rd_ack) rdata_q <= bus.ram_rdata;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors and sequences for the video RAM arbiter
module tb_vram_arbiter;
  logic clk = 1'b0, res = 1'b1;
  logic [9:0] x = '0, y = '0;
  logic [7:0] scroll_i = 8'd216;
  logic quarter_i = 1'b0, load_o;
  logic [15:0] data_o;
  logic [15:0] wmem [8192];
  logic [8191:0] wv;
  int total = 0, bad = 0;
  typedef struct { logic [9:0] x, y; logic en; logic [12:0] addr; } vec_t;
  vec_t tv [14];
  vram_if bus();
  vram_arbiter dut (
    .clk(clk), .res(res), .x(x), .y(y), .scroll_i(scroll_i), .quarter_i(quarter_i),
    .bus(bus), .data_o(data_o), .load_o(load_o)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] f(input logic [12:0] a);
    return {3'b101, a};
  endfunction
  function automatic logic [15:0] rd(input logic [12:0] a);
    return (wv[a] === 1'b1) ? wmem[a] : f(a);
  endfunction
  always @(posedge clk)
    if (bus.ram_en) begin
      bus.ram_rdata <= rd(bus.ram_addr);
      if (bus.ram_we) begin
        wmem[bus.ram_addr] <= (rd(bus.ram_addr) & ~{{8{bus.ram_be[1]}}, {8{bus.ram_be[0]}}})
                            | (bus.ram_wdata & {{8{bus.ram_be[1]}}, {8{bus.ram_be[0]}}});
        wv[bus.ram_addr] <= 1'b1;
      end
    end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic nxt(input logic [9:0] nx, input logic [9:0] ny);
    @(posedge clk);
    #1;
    x = nx;
    y = ny;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int held, nen, nld, nnz;
    tv[0]  = '{10'd20,  10'd10,  1'b1, 13'd7074};
    tv[1]  = '{10'd21,  10'd10,  1'b0, 13'd0};
    tv[2]  = '{10'd500, 10'd10,  1'b0, 13'd0};
    tv[3]  = '{10'd484, 10'd10,  1'b1, 13'd7103};
    tv[4]  = '{10'd4,   10'd10,  1'b1, 13'd7073};
    tv[5]  = '{10'd4,   10'd11,  1'b1, 13'd7073};
    tv[6]  = '{10'd4,   10'd12,  1'b1, 13'd7105};
    tv[7]  = '{10'd692, 10'd300, 1'b1, 13'd3520};
    tv[8]  = '{10'd692, 10'd625, 1'b1, 13'd6912};
    tv[9]  = '{10'd692, 10'd511, 1'b0, 13'd0};
    tv[10] = '{10'd20,  10'd520, 1'b0, 13'd0};
    tv[11] = '{10'd516, 10'd100, 1'b0, 13'd0};
    tv[12] = '{10'd36,  10'd255, 1'b1, 13'd2787};
    tv[13] = '{10'd692, 10'd10,  1'b1, 13'd7072};
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_be = '0; bus.cpu_wdata = '0;
    nxt(10'd20, 10'd10); smp;
    chk("reset ram_en", bus.ram_en, 0);
    nxt(10'd31, 10'd10); smp;
    chk("reset load_o", load_o, 0);
    chk("reset data_o", data_o, 0);
    chk("reset cpu_ack", bus.cpu_ack, 0);
    chk("reset ram_addr", bus.ram_addr, 0);
    nxt(10'd1, 10'd10); res = 1'b0; smp;
    chk("idle ram_en", bus.ram_en, 0);
    chk("idle cpu_rdata", bus.cpu_rdata, 0);
    for (int i = 0; i < 14; i++) begin
      nxt(tv[i].x, tv[i].y); smp;
      chk($sformatf("vec%0d ram_en", i), bus.ram_en, tv[i].en);
      chk($sformatf("vec%0d ram_addr", i), bus.ram_addr, tv[i].addr);
      chk($sformatf("vec%0d ram_we", i), bus.ram_we, 0);
    end
    for (int i = 20; i <= 32; i++) begin
      nxt(10'(i), 10'd10); smp;
      if (i == 30) chk("pre-load load_o", load_o, 0);
      if (i == 31) begin
        chk("fetch load_o", load_o, 1);
        chk("fetch data_o", data_o, f(13'd7074));
      end
      if (i == 32) begin
        chk("post-load load_o", load_o, 0);
        chk("post-load data_o", data_o, f(13'd7074));
      end
    end
    nxt(10'd40, 10'd10); bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'd100; smp;
    chk("rst-seq idle ram_en", bus.ram_en, 0);
    nxt(10'd41, 10'd10); smp;
    chk("rst-seq issue ram_en", bus.ram_en, 1);
    chk("rst-seq issue addr", bus.ram_addr, 100);
    nxt(10'd42, 10'd10); res = 1'b1; smp;
    chk("mid-reset cpu_ack", bus.cpu_ack, 0);
    chk("mid-reset data_o", data_o, 0);
    chk("mid-reset ram_en", bus.ram_en, 0);
    nxt(10'd52, 10'd10); smp;
    chk("mid-reset slot ram_en", bus.ram_en, 0);
    chk("mid-reset2 cpu_ack", bus.cpu_ack, 0);
    nxt(10'd53, 10'd10); res = 1'b0; smp;
    chk("after-reset cpu_ack", bus.cpu_ack, 0);
    chk("after-reset data_o", data_o, 0);
    nxt(10'd54, 10'd10); smp;
    chk("after-reset issue en", bus.ram_en, 1);
    chk("after-reset issue addr", bus.ram_addr, 100);
    nxt(10'd55, 10'd10); smp;
    chk("after-reset ack", bus.cpu_ack, 1);
    chk("after-reset rdata", bus.cpu_rdata, f(13'd100));
    nxt(10'd56, 10'd10); bus.cpu_req = 1'b0; smp;
    chk("after-reset ack pulse", bus.cpu_ack, 0);
    nxt(10'd57, 10'd10); smp;
    nxt(10'd35, 10'd12); bus.cpu_req = 1'b1; bus.cpu_addr = 13'd100; smp;
    chk("coll x35 ram_en", bus.ram_en, 0);
    nxt(10'd36, 10'd12); smp;
    chk("coll x36 ram_en", bus.ram_en, 1);
    chk("coll x36 disp addr", bus.ram_addr, 7107);
    chk("coll x36 ack", bus.cpu_ack, 0);
    nxt(10'd37, 10'd12); smp;
    chk("coll x37 ram_en", bus.ram_en, 1);
    chk("coll x37 cpu addr", bus.ram_addr, 100);
    nxt(10'd38, 10'd12); smp;
    chk("coll x38 ack", bus.cpu_ack, 1);
    chk("coll x38 rdata", bus.cpu_rdata, f(13'd100));
    chk("coll x38 ram_en", bus.ram_en, 0);
    held = 0;
    for (int i = 39; i <= 43; i++) begin
      nxt(10'(i), 10'd12); smp;
      held += int'(bus.ram_en) + int'(bus.cpu_ack);
    end
    chk("held req activity", held, 0);
    nxt(10'd44, 10'd12); bus.cpu_req = 1'b0; smp;
    nxt(10'd45, 10'd12); smp;
    nxt(10'd60, 10'd12);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'd200; bus.cpu_be = 2'b01; bus.cpu_wdata = 16'h1234;
    smp;
    nxt(10'd61, 10'd12); smp;
    chk("wr ram_en", bus.ram_en, 1);
    chk("wr ram_we", bus.ram_we, 1);
    chk("wr ram_be", bus.ram_be, 2'b01);
    chk("wr ram_wdata", bus.ram_wdata, 16'h1234);
    chk("wr ram_addr", bus.ram_addr, 200);
    nxt(10'd62, 10'd12); smp;
    chk("wr ack", bus.cpu_ack, 1);
    chk("wr rdata hold", bus.cpu_rdata, f(13'd100));
    nxt(10'd63, 10'd12); bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; smp;
    nxt(10'd64, 10'd12); smp;
    nxt(10'd65, 10'd12); bus.cpu_req = 1'b1; smp;
    nxt(10'd66, 10'd12); smp;
    chk("rdback ram_addr", bus.ram_addr, 200);
    chk("rdback ram_we", bus.ram_we, 0);
    nxt(10'd67, 10'd12); smp;
    chk("rdback ack", bus.cpu_ack, 1);
    chk("rdback rdata", bus.cpu_rdata, 16'hA034);
    nxt(10'd68, 10'd12); bus.cpu_req = 1'b0; smp;
    nxt(10'd69, 10'd12); smp;
    nxt(10'd692, 10'd510); smp;
    chk("prefetch y510 en", bus.ram_en, 1);
    chk("prefetch y510 addr", bus.ram_addr, 6880);
    nxt(10'd693, 10'd510); smp;
    nxt(10'd703, 10'd510); smp;
    chk("prefetch y510 load", load_o, 1);
    chk("prefetch y510 data", data_o, f(13'd6880));
    nxt(10'd692, 10'd511); smp;
    chk("prefetch y511 en", bus.ram_en, 0);
    nxt(10'd703, 10'd511); smp;
    chk("prefetch y511 load", load_o, 1);
    chk("prefetch y511 data", data_o, 0);
    nxt(10'd100, 10'd300); scroll_i = 8'd0; smp;
    nxt(10'd20, 10'd300); smp;
    chk("scroll midframe addr", bus.ram_addr, 3522);
    nxt(10'd0, 10'd620); smp;
    nxt(10'd20, 10'd10); smp;
    chk("scroll not yet latched", bus.ram_addr, 7074);
    nxt(10'd0, 10'd625); smp;
    nxt(10'd692, 10'd625); smp;
    chk("wrap en", bus.ram_en, 1);
    chk("wrap addr", bus.ram_addr, 0);
    nxt(10'd20, 10'd0); smp;
    chk("new frame addr", bus.ram_addr, 2);
    nxt(10'd0, 10'd625); quarter_i = 1'b1; smp;
    nxt(10'd20, 10'd383); smp;
    chk("quarter y383 en", bus.ram_en, 0);
    nxt(10'd20, 10'd384); smp;
    chk("quarter y384 addr", bus.ram_addr, 6146);
    nxt(10'd20, 10'd400); smp;
    chk("quarter y400 addr", bus.ram_addr, 6402);
    nen = 0; nld = 0; nnz = 0;
    for (int i = 0; i < 800; i++) begin
      nxt(10'(i), 10'd200); smp;
      nen += int'(bus.ram_en);
      if (load_o) begin
        nld++;
        if (data_o != 16'd0) nnz++;
      end
    end
    chk("quarter line ram_en count", nen, 0);
    chk("quarter line load count", nld, 50);
    chk("quarter line nonzero loads", nnz, 0);
    nxt(10'd35, 10'd200); bus.cpu_req = 1'b1; bus.cpu_addr = 13'd300; smp;
    nxt(10'd36, 10'd200); smp;
    chk("quarter cpu en", bus.ram_en, 1);
    chk("quarter cpu addr", bus.ram_addr, 300);
    nxt(10'd37, 10'd200); smp;
    chk("quarter cpu ack", bus.cpu_ack, 1);
    chk("quarter cpu rdata", bus.cpu_rdata, f(13'd300));
    nxt(10'd38, 10'd200); bus.cpu_req = 1'b0; smp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
